// File: rtl/multi_delay_pkg.sv
// Shared types, mode encodings and limits for the multi-channel delay block.
package multi_delay_pkg;

   localparam int NCH_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chan_state_e;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } chan_mode_e;

   // Channel-select width; never narrower than one bit.
   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_delay_if.sv
// Configuration write bus of the multi-channel delay block (valid/ready handshake).
interface multi_delay_if #(
   parameter int NCH   = 4,
   parameter int CBITS = 15
) ();
   import multi_delay_pkg::*;

   localparam int CHW = ch_bits(NCH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CHW-1:0]   cfg_ch;
   logic [CBITS-1:0] cfg_term;
   logic             cfg_mode;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_term,
      output cfg_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_term,
      input  cfg_mode,
      output cfg_ready
   );

endinterface

// File: rtl/multi_delay_chan.sv
// One delay channel: up-counter with terminal-count compare, periodic or one-shot.
// Sticky error logic is present only when MULTI_DELAY_ERR_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | stopped, cnt held at 0, no pulses
//   RUN     | counting; sig on cnt == term, then cnt back to 0
//   DONE    | one-shot finished; behaves as IDLE until start
module delay_chan
   import multi_delay_pkg::*;
#(
   parameter int CBITS = 15,
   parameter int DEF_N = 25000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             wr_en,
   input  logic [CBITS-1:0] wr_term,
   input  logic             wr_mode,
   input  logic             err_clr,
   output logic             sig,
   output logic             flg,
   output logic             err
);

   chan_state_e      state_q, state_d;
   chan_mode_e       mode_q, mode_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] term_q, term_d;
   logic             err_ev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_PERIODIC;
         cnt_q   <= '0;
         term_q  <= CBITS'(DEF_N);
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         term_q  <= term_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      term_d  = term_q;
      err_ev  = 1'b0;

      if (wr_en) begin
         term_d = wr_term;
         mode_d = chan_mode_e'(wr_mode);
      end

      if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (start) begin
         state_d = ST_RUN;
         cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (cnt_q == term_q) begin
            cnt_d = '0;
            if (mode_q == MODE_ONESHOT) begin
               state_d = ST_DONE;
            end
         end else if (cnt_q > term_q) begin
            cnt_d  = '0;
            err_ev = 1'b1;
         end else begin
            cnt_d = cnt_q + CBITS'(1);
         end
         // New terminal already passed: restart the period instead of wrapping 2^CBITS.
         if (wr_en && (wr_term < cnt_q)) begin
            cnt_d  = '0;
            err_ev = 1'b1;
         end
      end
   end

   assign sig = (state_q == ST_RUN) && (cnt_q == term_q);
   assign flg = (state_q == ST_RUN) && (cnt_q <= term_q);

`ifdef MULTI_DELAY_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_ev | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = err_ev ^ err_clr;
   assign err        = 1'b0;
`endif

endmodule

// File: rtl/multi_delay.sv
// NCH independent delay channels sharing one configuration write port.
// Optional sticky error reporting: define MULTI_DELAY_ERR_EN.
module multi_delay
   import multi_delay_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CBITS = 15,
   parameter int DEF_N = 25000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] start,
   input  logic [NCH-1:0] stop,
   input  logic [NCH-1:0] err_clr,
   output logic [NCH-1:0] sig,
   output logic [NCH-1:0] flg,
   output logic [NCH-1:0] err,
   multi_delay_if.slave   cfg
);

   logic           cfg_ready_q, cfg_ready_d;
   logic           wr_acc;
   logic [NCH-1:0] wr_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready_q <= 1'b0;
      end else begin
         cfg_ready_q <= cfg_ready_d;
      end
   end

   // Out-of-range channel numbers match no decode bit, so such writes are silently dropped.
   always_comb begin
      wr_acc      = cfg.cfg_valid & cfg_ready_q;
      cfg_ready_d = ~wr_acc;
      wr_sel      = '0;
      for (int i = 0; i < NCH; i++) begin
         wr_sel[i] = wr_acc && (int'(cfg.cfg_ch) == i);
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      delay_chan #(
         .CBITS (CBITS),
         .DEF_N (DEF_N)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start[g]),
         .stop    (stop[g]),
         .wr_en   (wr_sel[g]),
         .wr_term (cfg.cfg_term),
         .wr_mode (cfg.cfg_mode),
         .err_clr (err_clr[g]),
         .sig     (sig[g]),
         .flg     (flg[g]),
         .err     (err[g])
      );
   end

endmodule
